// File: rtl/f5_sweep_pkg.sv
// Shared types and constants for the f5 sweep-and-compare stage.
package f5_sweep_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Width of a counter that must reach the value settle (never narrower than 1 bit).
  function automatic int wait_width(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

  localparam int N_DEF      = 3;
  localparam int SETTLE_DEF = 1;
  localparam int NVEC       = 2 ** N_DEF;
  localparam int WAIT_W     = wait_width(SETTLE_DEF);

  // Truth table of f5 over vec = {a,b,c}: bit i is f5(i).
  localparam logic [7:0] F5_TABLE = 8'hA2;

endpackage

// File: rtl/f5_sweep_counter.sv
// Vector and hold-time counter for the sweep: each vector is held SETTLE+1
// steps, the vector saturates at its last value instead of wrapping.
module f5_sweep_counter
  import f5_sweep_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_step,
  output logic [N-1:0] o_vec,
  output logic         o_last_wait,
  output logic         o_last_vec
);

  localparam int            WW       = wait_width(SETTLE);
  localparam logic [WW-1:0] W_LAST   = WW'(SETTLE);
  localparam logic [N-1:0]  VEC_LAST = '1;

  logic [N-1:0]  r_vec;
  logic [WW-1:0] r_wait;

  // Load clears both counters; a step advances the hold counter, then the vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vec  <= '0;
      r_wait <= '0;
    end else if (i_load) begin
      r_vec  <= '0;
      r_wait <= '0;
    end else if (i_step) begin
      if (r_wait == W_LAST) begin
        r_wait <= '0;
        if (r_vec != VEC_LAST) begin
          r_vec <= r_vec + N'(1);
        end else begin
          r_vec <= r_vec;
        end
      end else begin
        r_wait <= r_wait + WW'(1);
      end
    end else begin
      r_vec  <= r_vec;
      r_wait <= r_wait;
    end
  end

  assign o_vec       = r_vec;
  assign o_last_wait = (r_wait == W_LAST);
  assign o_last_vec  = (r_vec == VEC_LAST);

endmodule

// File: rtl/f5_sweep_checker.sv
// Sweep-and-compare stage: walks every input vector, captures the reference
// and simplified implementation outputs into truth tables, counts mismatches
// and records the first failing vector.
module f5_sweep_checker
  import f5_sweep_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [N-1:0]      vec,
  input  logic              s_ref,
  input  logic              s_dut,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N:0]        mism_cnt,
  output logic [N-1:0]      first_bad,
  output logic [2**N-1:0]   table_ref,
  output logic [2**N-1:0]   table_dut
);

  localparam int NV = 2 ** N;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_load;
  logic            w_step;
  logic            w_sample;
  logic            w_mismatch;
  logic [N:0]      w_mism_nxt;
  logic [N-1:0]    w_vec;
  logic            w_last_wait;
  logic            w_last_vec;

  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [N:0]      r_mism;
  logic [N-1:0]    r_first_bad;
  logic [NV-1:0]   r_table_ref;
  logic [NV-1:0]   r_table_dut;

  f5_sweep_counter #(
    .N      (N),
    .SETTLE (SETTLE)
  ) u_counter (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_step      (w_step),
    .o_vec       (w_vec),
    .o_last_wait (w_last_wait),
    .o_last_vec  (w_last_vec)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and counter control; sampling happens on the last hold cycle of a vector.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last_wait) begin
          w_sample = 1'b1;
          if (w_last_vec) begin
            w_state_nxt = FIN;
          end else begin
            w_state_nxt = RUN;
          end
        end else begin
          w_state_nxt = RUN;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_mismatch = w_sample & (s_ref ^ s_dut);
  assign w_mism_nxt = r_mism + {{N{1'b0}}, w_mismatch};

  // Result registers: cleared on accept, updated on each sample, pass latched on FIN entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_mism      <= '0;
      r_first_bad <= '0;
      r_table_ref <= '0;
      r_table_dut <= '0;
    end else begin
      r_busy <= (w_state_nxt == RUN);
      r_done <= (w_state_nxt == FIN);
      if (w_load) begin
        r_pass      <= 1'b0;
        r_mism      <= '0;
        r_first_bad <= '0;
        r_table_ref <= '0;
        r_table_dut <= '0;
      end else begin
        if (w_sample) begin
          r_table_ref[w_vec] <= s_ref;
          r_table_dut[w_vec] <= s_dut;
        end
        if (w_mismatch) begin
          r_mism <= w_mism_nxt;
          if (r_mism == '0) begin
            r_first_bad <= w_vec;
          end
        end
        if ((r_state == RUN) && (w_state_nxt == FIN)) begin
          r_pass <= (w_mism_nxt == '0);
        end
      end
    end
  end

  assign vec       = w_vec;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign mism_cnt  = r_mism;
  assign first_bad = r_first_bad;
  assign table_ref = r_table_ref;
  assign table_dut = r_table_dut;

endmodule

// File: doc/f5_sweep_checker.md
Name: f5_sweep_checker

Overview:
- Sequential sweep-and-compare stage that wraps the 3-input f5 logic functions.
- On start, drives every input vector 0..2^N-1 to two externally instantiated implementations (unsimplified reference, simplified DUT), captures both outputs, and builds their truth tables.
- Counts mismatches and records the first failing vector; reports pass/done.
- Acts as the stimulus source feeding f5 and the consumer of its outputs, replacing hand-written vector lists.

Parameters:
- N, 3: number of function inputs; vec width.
- SETTLE, 1: extra cycles each vector is held before sampling (>= 0).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a sweep; sampled only in IDLE.
- vec  out  N  stimulus {a,b,c}, MSB = a; shared by both implementations.
- s_ref  in  1  output of the unsimplified implementation.
- s_dut  in  1  output of the simplified implementation.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse at sweep completion.
- pass  out  1  level; 1 if the last completed sweep had zero mismatches.
- mism_cnt  out  N+1  mismatch count of the current/last sweep (0..2^N).
- first_bad  out  N  first vector where s_ref != s_dut; valid only when mism_cnt != 0.
- table_ref  out  2^N  bit i = s_ref sampled at vec = i.
- table_dut  out  2^N  bit i = s_dut sampled at vec = i.

Behaviour:
- Reset (async, immediate): state = IDLE; all outputs 0, including vec, pass, the tables, and the counters.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - When start = 1, at the edge: vec <= 0, wait counter <= 0, mism_cnt/tables/first_bad/pass <= 0, busy <= 1, go to RUN.
  - When start = 0: hold all outputs.
- RUN:
  - Each vector is held for SETTLE+1 cycles.
  - When the wait counter equals SETTLE, the edge samples s_ref/s_dut into bit vec of the tables.
  - On mismatch, the same edge increments mism_cnt; if mism_cnt was 0, it also loads first_bad <= vec.
  - At that same edge: vec <= vec+1 and wait counter <= 0. If vec was 2^N-1, go to FIN instead; vec holds 2^N-1 and does not wrap.
  - Otherwise the edge increments the wait counter.
- FIN (one cycle): done = 1, busy = 0, pass = (mism_cnt == 0); the next edge goes to IDLE.
  - done is a Moore output of FIN.
  - pass is registered at the FIN entry edge, then held until the next accepted start.
- Latency:
  - busy is high for exactly 2^N*(SETTLE+1) cycles after the accept edge.
  - done is high in the following cycle.
  - Defaults: 16 cycles busy, done in cycle 17.
- start is ignored in RUN and FIN; there is no queuing.
- Inputs s_ref/s_dut are assumed combinational from vec. With SETTLE = 0, sampling occurs in the same cycle vec is presented.
- mism_cnt is N+1 bits so that an all-mismatch sweep (2^N) does not overflow.
- Reset mid-sweep aborts: no done pulse, results cleared; a later start runs a full sweep.
- Tables, mism_cnt and first_bad hold after FIN until the next accepted start.

Decomposition:
- Package f5_sweep_pkg:
  - state enum {IDLE, RUN, FIN};
  - localparams NVEC = 2**N and the wait-counter width $clog2(SETTLE+1) (minimum 1);
  - shared truth-table constant F5_TABLE = 8'hA2 for benches.
- One sub-module, f5_sweep_counter: vec and wait counter with load/step/last-flag outputs.
- The FSM, comparison and result registers stay in f5_sweep_checker.

Test Plan:
- Both inputs driven by the f5 sum-of-products and simplified forms; pulse start -> busy for 16 cycles, then done for 1 cycle. Expected: table_ref = table_dut = 8'hA2, mism_cnt = 0, pass = 1.
- s_dut = ~s_ref -> mism_cnt = 4'd8, first_bad = 3'b000, pass = 0, table_dut = 8'h5D.
- Faulty DUT s = a&c -> mism_cnt = 1, first_bad = 3'b001, table_dut = 8'hA0, pass = 0.
- start re-pulsed at cycles 3 and 16 of a sweep -> ignored; sweep ends at the normal time. A new start after done clears mism_cnt/tables at the accept edge and reruns.
- reset asserted asynchronously mid-cycle at cycle 5 of RUN -> all outputs 0 immediately, no done. The next start yields the full correct sweep (8'hA2, pass = 1).
- Parameter SETTLE = 0 -> busy for 8 cycles, vec increments every cycle, same results as scenario 1. SETTLE = 3 -> busy for 32 cycles.
